// File: rtl/aer_event_dispatcher.sv
// aer_event_dispatcher
//   Drains the neuron-index FIFO filled by the spike filter and issues one
//   4-phase AER event per entry to the tinyODIN AERIN interface. It signals
//   end of time step and counts the events dispatched in the current step.
//
// Ports
//   CLK, RSTN          clock, asynchronous active-low reset
//   enable_i           level, permits new FIFO pops
//   FIFO_r_en_o        FIFO pop strobe (one cycle per entry)
//   FIFO_r_data_i      FIFO head data, valid the cycle after FIFO_r_en_o
//   FIFO_empty_i       FIFO empty flag
//   spikecore_done_i   level, spike filter finished scanning this tick
//   AERIN_ADDR_o       {1'b0, neuron_idx, M'b0}, flop-driven
//   AERIN_REQ_o        AER request, flop-driven
//   AERIN_ACK_i        AER acknowledge, asynchronous to CLK
//   event_cnt_o        saturating count of events completed this step
//   step_done_o        one-cycle end-of-step pulse
//   busy_o             high in any state other than IDLE and DONE
//   dbg_state_o        current FSM state encoding (debug)
//
// Handshake (4-phase): REQ rises with a stable ADDR; the core raises ACK;
// REQ falls only after synchronised ACK is seen high; the event completes
// when synchronised ACK is seen low again. ADDR never changes while REQ is
// high and REQ is never withdrawn before ACK.
module aer_event_dispatcher #(
  parameter int M           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             enable_i,
  output logic             FIFO_r_en_o,
  input  logic [M-1:0]     FIFO_r_data_i,
  input  logic             FIFO_empty_i,
  input  logic             spikecore_done_i,
  output logic [2*M:0]     AERIN_ADDR_o,
  output logic             AERIN_REQ_o,
  input  logic             AERIN_ACK_i,
  output logic [CNT_W-1:0] event_cnt_o,
  output logic             step_done_o,
  output logic             busy_o,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_REQ   = 3'd3,
    S_ACKLO = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   ack_s;
  logic [M-1:0]           addr_q, addr_d;
  logic                   req_q, req_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   step_done_q, step_done_d;

  // ACK synchroniser: shift in at bit 0, use the oldest stage.
  assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], AERIN_ACK_i};
  assign ack_s      = ack_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // Pending entries take priority over end of step, so a late
        // spikecore_done_i still lets the FIFO drain first.
        if (enable_i && !FIFO_empty_i) begin
          state_d = S_POP;
        end else if (spikecore_done_i && FIFO_empty_i) begin
          state_d = S_DONE;
        end
      end
      S_POP: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        addr_d  = FIFO_r_data_i;
        req_d   = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = S_ACKLO;
        end
      end
      S_ACKLO: begin
        if (!ack_s) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (!spikecore_done_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pulse only on the transition into DONE, not while it is held.
  assign step_done_d = (state_d == S_DONE) && (state_q != S_DONE);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      ack_sync_q  <= '0;
      addr_q      <= '0;
      req_q       <= 1'b0;
      cnt_q       <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_sync_q  <= ack_sync_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      step_done_q <= step_done_d;
    end
  end

  // All outputs decode flops only; no input reaches them combinationally.
  assign FIFO_r_en_o  = (state_q == S_POP);
  assign AERIN_ADDR_o = {1'b0, addr_q, {M{1'b0}}};
  assign AERIN_REQ_o  = req_q;
  assign event_cnt_o  = cnt_q;
  assign step_done_o  = step_done_q;
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign dbg_state_o  = state_q;

endmodule
